// File: rtl/as5600_pkg.sv
// Shared state encoding and width constants for the AS5600 multi-turn unwrapper.
package as5600_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam int POS_W = 32;

    // The wrap-corrected delta is the raw angle difference read back as signed.
    function automatic int deltaWidth(input int angleBits);
        return angleBits;
    endfunction

endpackage

// File: rtl/as5600_unwrap_if.sv
// Sample/position bus between the AS5600 reader, the unwrapper and the register block.
interface as5600_unwrap_if #(
    parameter int ANGLE_BITS = 12
);
    logic [ANGLE_BITS-1:0] angle_in;
    logic                  angle_valid;
    logic                  zero_req;
    logic signed [31:0]    position;
    logic                  position_valid;
    logic                  locked;
    logic [15:0]           glitch_count;
    logic signed [31:0]    velocity;
    logic                  velocity_valid;

    modport master (
        output angle_in, angle_valid, zero_req,
        input  position, position_valid, locked, glitch_count, velocity, velocity_valid
    );

    modport slave (
        input  angle_in, angle_valid, zero_req,
        output position, position_valid, locked, glitch_count, velocity, velocity_valid
    );
endinterface

// File: rtl/as5600_vel_gate.sv
// Windowed velocity: position difference over each VEL_WINDOW-cycle gate.
module as5600_vel_gate #(
    parameter int VEL_WINDOW = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               zero_req,
    input  logic signed [31:0] position,
    output logic signed [31:0] velocity,
    output logic               velocity_valid
);
    localparam int CNT_W = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;

    logic [CNT_W-1:0]   count_q, count_d;
    logic signed [31:0] snapshot_q, snapshot_d;
    logic signed [31:0] velocity_q, velocity_d;
    logic               velValid_q, velValid_d;
    logic               wrap;

    assign wrap = (count_q == CNT_W'(VEL_WINDOW - 1));

    // A zero request realigns the gate with the new origin and suppresses that window's report.
    always_comb begin
        count_d    = wrap ? '0 : count_q + CNT_W'(1);
        snapshot_d = snapshot_q;
        velocity_d = velocity_q;
        velValid_d = 1'b0;
        if (zero_req) begin
            count_d    = '0;
            snapshot_d = '0;
        end else if (wrap) begin
            velocity_d = position - snapshot_q;
            snapshot_d = position;
            velValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            snapshot_q <= '0;
            velocity_q <= '0;
            velValid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            snapshot_q <= snapshot_d;
            velocity_q <= velocity_d;
            velValid_q <= velValid_d;
        end
    end

    assign velocity       = velocity_q;
    assign velocity_valid = velValid_q;
endmodule

// File: rtl/as5600_unwrap.sv
// Multi-turn unwrapper with glitch rejection and lock status for the AS5600 angle stream.
// Optional velocity gate is enabled by defining AS5600_UNWRAP_VEL_EN.
module as5600_unwrap
    import as5600_pkg::*;
#(
    parameter int ANGLE_BITS   = 12,
    parameter int MAX_STEP     = 1024,
    parameter int GLITCH_LIMIT = 3,
    parameter int VEL_WINDOW   = 1000000
) (
    input logic            clk,
    input logic            rst,
    as5600_unwrap_if.slave bus
);
    localparam int DELTA_W  = deltaWidth(ANGLE_BITS);
    localparam int CONSEC_W = $clog2(GLITCH_LIMIT + 1);

    state_t                state_q, state_d;
    logic [ANGLE_BITS-1:0] lastAngle_q, lastAngle_d;
    logic signed [31:0]    position_q, position_d;
    logic                  posValid_q, posValid_d;
    logic [15:0]           glitchCount_q, glitchCount_d;
    logic [CONSEC_W-1:0]   consec_q, consec_d;

    logic [DELTA_W-1:0]    deltaRaw;
    logic signed [31:0]    deltaExt;
    logic [31:0]           deltaMag;
    logic                  accept;
    logic                  glitchTrip;

    // Modular subtraction gives the shortest signed path across the turn boundary.
    assign deltaRaw   = bus.angle_in - lastAngle_q;
    assign deltaExt   = {{(POS_W - DELTA_W){deltaRaw[DELTA_W-1]}}, deltaRaw};
    assign deltaMag   = deltaExt[POS_W-1] ? -deltaExt : deltaExt;
    assign accept     = (deltaMag <= 32'(MAX_STEP));
    assign glitchTrip = ((32'(consec_q) + 32'd1) >= 32'(GLITCH_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            lastAngle_q   <= '0;
            position_q    <= '0;
            posValid_q    <= 1'b0;
            glitchCount_q <= '0;
            consec_q      <= '0;
        end else begin
            state_q       <= state_d;
            lastAngle_q   <= lastAngle_d;
            position_q    <= position_d;
            posValid_q    <= posValid_d;
            glitchCount_q <= glitchCount_d;
            consec_q      <= consec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        if (bus.zero_req) begin
            if (bus.angle_valid) begin
                state_d  = ST_TRACK;
                consec_d = '0;
            end
        end else if (bus.angle_valid) begin
            case (state_q)
                ST_TRACK: begin
                    if (accept) begin
                        consec_d = '0;
                    end else if (glitchTrip) begin
                        state_d  = ST_RESYNC;
                        consec_d = '0;
                    end else begin
                        consec_d = consec_q + CONSEC_W'(1);
                    end
                end
                default: begin
                    state_d  = ST_TRACK;
                    consec_d = '0;
                end
            endcase
        end
    end

    // Seeding samples (INIT/RESYNC) only move the reference, never the position.
    always_comb begin
        position_d    = position_q;
        lastAngle_d   = lastAngle_q;
        posValid_d    = 1'b0;
        glitchCount_d = glitchCount_q;
        if (bus.zero_req) begin
            position_d = '0;
            posValid_d = 1'b1;
            if (bus.angle_valid) begin
                lastAngle_d = bus.angle_in;
            end
        end else if (bus.angle_valid) begin
            if (state_q == ST_TRACK) begin
                if (accept) begin
                    position_d  = position_q + deltaExt;
                    lastAngle_d = bus.angle_in;
                    posValid_d  = 1'b1;
                end else if (glitchCount_q != 16'hFFFF) begin
                    glitchCount_d = glitchCount_q + 16'd1;
                end
            end else begin
                lastAngle_d = bus.angle_in;
            end
        end
    end

    assign bus.position       = position_q;
    assign bus.position_valid = posValid_q;
    assign bus.locked         = (state_q == ST_TRACK);
    assign bus.glitch_count   = glitchCount_q;

    if (VEL_WINDOW < 2) begin : gVelWindowCheck
        $error("as5600_unwrap: VEL_WINDOW must be at least 2");
    end

`ifdef AS5600_UNWRAP_VEL_EN
    as5600_vel_gate #(
        .VEL_WINDOW(VEL_WINDOW)
    ) uVelGate (
        .clk            (clk),
        .rst            (rst),
        .zero_req       (bus.zero_req),
        .position       (position_q),
        .velocity       (bus.velocity),
        .velocity_valid (bus.velocity_valid)
    );
`else
    assign bus.velocity       = '0;
    assign bus.velocity_valid = 1'b0;
`endif
endmodule
